// File: rtl/led_sequencer.sv
// LED count sequencer: prescales clk into step events and advances a CNT_W-bit
// count in up, down, ping-pong or hold mode under a valid/ready command interface.
module led_sequencer #(
  parameter int CNT_W    = 3,
  parameter int TICK_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_run,
  input  logic             cmd_clear,
  output logic [CNT_W-1:0] led_count,
  output logic             step_tick,
  output logic             wrap,
  output logic             busy
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        mode_q, mode_d;
  logic              dir_q, dir_d;        // 1 = moving down
  logic [1:0]        pend_mode_q, pend_mode_d;
  logic              pend_run_q, pend_run_d;
  logic              pend_clear_q, pend_clear_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;

  logic accept;
  logic tick_last;
  logic wrap_now;

  assign cmd_ready = reset_n && (state_q != S_LOAD);
  assign accept    = cmd_valid && cmd_ready;
  assign tick_last = (tick_q == TICK_LAST);

  assign led_count = count_q;
  assign step_tick = step_q;
  assign wrap      = wrap_q;
  assign busy      = (state_q == S_RUN);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    tick_d       = tick_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    pend_mode_d  = pend_mode_q;
    pend_run_d   = pend_run_q;
    pend_clear_d = pend_clear_q;
    step_d       = 1'b0;
    wrap_d       = 1'b0;
    wrap_now     = 1'b0;

    if (accept) begin
      pend_mode_d  = cmd_mode;
      pend_run_d   = cmd_run;
      pend_clear_d = cmd_clear;
    end

    unique case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (accept) state_d = S_LOAD;
      end

      S_LOAD: begin
        mode_d = pend_mode_q;
        dir_d  = (pend_mode_q == MODE_DOWN);
        tick_d = '0;
        if (pend_clear_q) count_d = CNT_ZERO;
        state_d = pend_run_q ? S_RUN : S_IDLE;
      end

      S_RUN: begin
        tick_d = tick_last ? '0 : tick_q + TICK_ONE;
        if (tick_last) begin
          unique case (mode_q)
            MODE_UP: begin
              count_d  = count_q + CNT_ONE;
              wrap_now = (count_q == CNT_MAX);
            end
            MODE_DOWN: begin
              count_d  = count_q - CNT_ONE;
              wrap_now = (count_q == CNT_ZERO);
            end
            MODE_PP: begin
              if (!dir_q) begin
                if (count_q == CNT_MAX) begin
                  dir_d    = 1'b1;
                  count_d  = CNT_MAX - CNT_ONE;
                  wrap_now = 1'b1;
                end else begin
                  count_d = count_q + CNT_ONE;
                end
              end else begin
                if (count_q == CNT_ZERO) begin
                  dir_d    = 1'b0;
                  count_d  = CNT_ONE;
                  wrap_now = 1'b1;
                end else begin
                  count_d = count_q - CNT_ONE;
                end
              end
            end
            default: ;
          endcase
          // A step taken as a command is accepted still updates the count, but its
          // pulses would land in the LOAD cycle, so they are suppressed.
          step_d = !accept;
          wrap_d = wrap_now && !accept;
        end
        if (accept) state_d = S_LOAD;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      tick_q       <= '0;
      mode_q       <= MODE_UP;
      dir_q        <= 1'b0;
      pend_mode_q  <= MODE_UP;
      pend_run_q   <= 1'b0;
      pend_clear_q <= 1'b0;
      step_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      tick_q       <= tick_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      pend_mode_q  <= pend_mode_d;
      pend_run_q   <= pend_run_d;
      pend_clear_q <= pend_clear_d;
      step_q       <= step_d;
      wrap_q       <= wrap_d;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV=4, CNT_W=3.
module tb_led_sequencer;

  localparam int CNT_W    = 3;
  localparam int TICK_DIV = 4;

  logic             clk;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic             cmd_run;
  logic             cmd_clear;
  logic [CNT_W-1:0] led_count;
  logic             step_tick;
  logic             wrap;
  logic             busy;

  int n_chk;
  int n_err;
  int spurious;

  led_sequencer #(.CNT_W(CNT_W), .TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode (cmd_mode),
    .cmd_run  (cmd_run),
    .cmd_clear(cmd_clear),
    .led_count(led_count),
    .step_tick(step_tick),
    .wrap     (wrap),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-step cycles: any step_tick or wrap here is spurious.
  task automatic quiet_tick();
    tick();
    if (step_tick || wrap) spurious++;
  endtask

  // Returns in the LOAD cycle following acceptance.
  task automatic send_cmd(input logic [1:0] m, input logic r, input logic c);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_run   = r;
    cmd_clear = c;
    while (!cmd_ready && n < 10) begin
      tick();
      n++;
    end
    chk("cmd_ready_before_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_mode  = 2'($urandom_range(0, 3));
    cmd_run   = 1'($urandom_range(0, 1));
    cmd_clear = 1'($urandom_range(0, 1));
  endtask

  // Called on the cycle a step result is visible (or RUN's first cycle); checks next step.
  task automatic step_chk(input string tag, input int exp_cnt, input int exp_wrap);
    repeat (TICK_DIV - 1) quiet_tick();
    tick();
    chk({tag, "_count"}, 32'(led_count), 32'(exp_cnt));
    chk({tag, "_tick"}, 32'(step_tick), 1);
    chk({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap));
  endtask

  int pp_seq[16]  = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  int pp_wrap[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk     = 0;
    n_err     = 0;
    spurious  = 0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    cmd_run   = 1'b0;
    cmd_clear = 1'b0;

    // Reset and idle
    tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_count", 32'(led_count), 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("idle_count", 32'(led_count), 0);
    chk("idle_busy", busy, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    repeat (20) quiet_tick();
    chk("idle_no_tick", spurious, 0);

    // Up count with wrap
    send_cmd(2'b00, 1'b1, 1'b1);
    chk("up_load_ready", cmd_ready, 0);
    chk("up_load_busy", busy, 0);
    tick();
    chk("up_run_busy", busy, 1);
    for (int k = 1; k <= 8; k++)
      step_chk($sformatf("up%0d", k), k % 8, (k == 8) ? 1 : 0);

    // Ping-pong from zero
    send_cmd(2'b10, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 16; k++)
      step_chk($sformatf("pp%0d", k), pp_seq[k], pp_wrap[k]);

    // Down from zero, stop, resume
    send_cmd(2'b01, 1'b1, 1'b1);
    tick();
    step_chk("dn1", 7, 1);
    step_chk("dn2", 6, 0);
    step_chk("dn3", 5, 0);
    send_cmd(2'b01, 1'b0, 1'b0);
    tick();
    chk("stop_busy", busy, 0);
    chk("stop_count", 32'(led_count), 5);
    repeat (10) quiet_tick();
    chk("stop_count_held", 32'(led_count), 5);
    send_cmd(2'b01, 1'b1, 1'b0);
    tick();
    step_chk("resume", 4, 0);

    // Command accepted on the step cycle, no clear
    send_cmd(2'b00, 1'b1, 1'b1);
    tick();
    step_chk("cs_up1", 1, 0);
    step_chk("cs_up2", 2, 0);
    step_chk("cs_up3", 3, 0);
    repeat (TICK_DIV - 1) quiet_tick();
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    cmd_run   = 1'b1;
    cmd_clear = 1'b0;
    #1;
    chk("cs_ready_on_step", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("cs_load_count", 32'(led_count), 4);
    chk("cs_load_ready", cmd_ready, 0);
    chk("cs_load_tick", step_tick, 0);
    chk("cs_load_busy", busy, 0);
    tick();
    step_chk("cs_dn1", 3, 0);
    step_chk("cs_dn2", 2, 0);

    // Command accepted on the step cycle, with clear
    repeat (TICK_DIV - 1) quiet_tick();
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    cmd_run   = 1'b1;
    cmd_clear = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("csc_load_count", 32'(led_count), 1);
    tick();
    chk("csc_after_load", 32'(led_count), 0);
    step_chk("csc_dn1", 7, 1);
    step_chk("csc_dn2", 6, 0);
    step_chk("csc_dn3", 5, 0);

    // Hold mode, then reset mid-run
    send_cmd(2'b11, 1'b1, 1'b0);
    tick();
    step_chk("hold1", 5, 0);
    step_chk("hold2", 5, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", cmd_ready, 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("mid_rst_count", 32'(led_count), 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready_idle", cmd_ready, 1);
    chk("mid_rst_tick", step_tick, 0);
    repeat (8) quiet_tick();
    chk("no_spurious_pulses", spurious, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Controller that sequences the 3-bit LED counter datapath. It converts the fast board clock into step events with a prescaler.
- It advances the LED count according to a commanded mode: up, down, ping-pong or hold.
- Commands arrive over a valid/ready handshake from the button/UI logic. The block sits between the input debouncers and the LED drivers.

Parameters:
- CNT_W, 3, width of led_count; the maximum count is 2^CNT_W-1.
- TICK_DIV, 1000, clk cycles per count step (1 step/s at 1 kHz clk); legal range is 1 or greater.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold.
- cmd_run  input  1  1 = run after load, 0 = stop after load.
- cmd_clear  input  1  1 = zero led_count during load.
- led_count  output  CNT_W  current LED count (registered).
- step_tick  output  1  one-cycle pulse on each step.
- wrap  output  1  one-cycle pulse on wrap or bounce.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE, led_count=0, tick_cnt=0, mode=up, dir=up.
  - step_tick=0, wrap=0, busy=0.
  - cmd_ready=0 while reset_n is low.
- FSM states:
  - IDLE: cmd_ready=1, busy=0, tick_cnt held at 0, count frozen. cmd_valid&&cmd_ready moves to LOAD.
  - LOAD: lasts exactly 1 cycle, cmd_ready=0. The block:
    - latches mode (captured at acceptance);
    - sets dir=up for modes 00 and 10, dir=down for mode 01;
    - clears tick_cnt;
    - sets led_count=0 if cmd_clear was 1.
    - Next state is RUN if cmd_run was 1, otherwise IDLE.
  - RUN: cmd_ready=1, busy=1.
    - tick_cnt increments each cycle.
    - When tick_cnt==TICK_DIV-1: tick_cnt is set to 0, a step is performed, and step_tick=1 that cycle (registered, visible the next cycle together with the new led_count).
    - An accepted command moves the FSM to LOAD.
- Step rules (width CNT_W, modulo arithmetic):
  - up: count+1; max to 0 pulses wrap.
  - down: count-1; 0 to max pulses wrap.
  - ping-pong, moving up: at max, set dir=down and count=max-1 and pulse wrap; otherwise count+1.
  - ping-pong, moving down: at 0, set dir=up and count=1 and pulse wrap; otherwise count-1.
  - hold: count unchanged, step_tick still pulses, no wrap.
- Latency:
  - The first step after entering RUN occurs TICK_DIV cycles after the LOAD cycle.
  - Steps then repeat every TICK_DIV cycles.
  - With TICK_DIV=1, the block steps every RUN cycle.
- Simultaneous events:
  - A command accepted on the step cycle: the step executes with the old mode/dir, then LOAD applies the new one. cmd_clear in LOAD overrides the stepped value.
- Count is preserved across commands unless cmd_clear=1. A stop (cmd_run=0) freezes led_count at its current value.
- Reset asserted mid-RUN or mid-LOAD: all state returns to reset values at that edge; any pending command is dropped.
- cmd_* inputs are sampled only when cmd_valid&&cmd_ready; they are don't-care otherwise.
- step_tick and wrap are never high in IDLE or LOAD cycles.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles, then release.
  - Required: led_count=0, busy=0, cmd_ready=1 on the first cycle after release.
  - Required: no step_tick for 20 cycles.
- Up count and wrap (TICK_DIV=4): command mode=00, run=1, clear=1.
  - Required: led_count goes 1,2,...,7,0 at 4-cycle spacing, the first step 4 cycles after LOAD.
  - Required: wrap pulses exactly once, on the 7 to 0 step.
- Ping-pong: clear, then run mode=10 for 16 steps.
  - Required: sequence 1..7,6..0,1,2, with wrap pulses at the 7 to 6 and 0 to 1 steps only.
- Down, then stop/resume: mode=01 from 0.
  - Required: first step gives 7 with a wrap pulse.
  - After 3 steps (count=5), issue run=0. Required: count stays 5 and busy=0.
  - Issue run=1 with clear=0, mode=01. Required: next step gives 4.
- Command on step cycle: in RUN mode=00 at count=3, assert a command (mode=01, clear=0) exactly when tick_cnt=TICK_DIV-1.
  - Required: count becomes 4, LOAD follows, then steps 3,2,...
  - Repeat with clear=1. Required: count=0 after LOAD.
- Reset mid-run and hold mode: while running mode=11 at count=5, step_tick pulses but count stays 5.
  - Pull reset_n low for 1 cycle. Required: led_count=0, state IDLE, busy=0 on the next cycle.
